// File: rtl/project_switch_ctrl_pkg.sv
// Shared types and register layout for the project switch controller.
// Config/status register bit positions and the one-hot helper.
package project_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD,
    RUN,
    DRAIN,
    GATE
  } state_e;

  localparam int PIN_MODE_BIT = 7;
  localparam int CLR_BIT      = 8;
  localparam int PEND_BIT     = 16;
  localparam int SW_BIT       = 17;
  localparam int ERR_INV_BIT  = 18;
  localparam int ERR_TO_BIT   = 19;

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/project_switch_ctrl_cfg_sync.sv
// Two-flop synchroniser for the select pins, plus a change strobe
// raised for one cycle whenever the synchronised value moves.
module project_switch_ctrl_cfg_sync
  import project_switch_ctrl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         chg_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o   = s2_q;
  assign chg_o = (s2_q != s3_q);

endmodule

// File: rtl/project_switch_ctrl.sv
// Owner scheduler for the multiplexed user projects: drains the bus,
// gates clocks, holds the new owner in reset, then hands it the datapath.
module project_switch_ctrl
  import project_switch_ctrl_pkg::*;
#(
  parameter int          USER_PROJECTS = 4,
  parameter int          CFG_BITS      = 2,
  parameter logic [31:0] CFG_ADDRESS   = 32'h300FFFFC,
  parameter int          DEFAULT_SEL   = 0,
  parameter int          GATE_CYCLES   = 2,
  parameter int          RST_CYCLES    = 4,
  parameter int          DRAIN_TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     cfg_hit_o,
  output logic                     cfg_ack_o,
  output logic [31:0]              cfg_dat_o,
  input  logic [CFG_BITS-1:0]      pin_sel_i,
  output logic [CFG_BITS-1:0]      active_sel_o,
  output logic [USER_PROJECTS-1:0] proj_clk_en_o,
  output logic [USER_PROJECTS-1:0] proj_rst_o,
  output logic                     switching_o
);

  localparam int MAX_A = (RST_CYCLES > GATE_CYCLES) ?
                         RST_CYCLES : GATE_CYCLES;
  localparam int CNT_MAX = (DRAIN_TIMEOUT > MAX_A) ?
                           DRAIN_TIMEOUT : MAX_A;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP    = CW'(CNT_MAX);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] GATE_LAST  = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CFG_BITS-1:0] DEF  = CFG_BITS'(DEFAULT_SEL);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CFG_BITS-1:0]      act_q, act_d;
  logic [CFG_BITS-1:0]      swt_q, swt_d;
  logic [CFG_BITS-1:0]      ptgt_q, ptgt_d;
  logic                     pend_q, pend_d;
  logic                     pinm_q, pinm_d;
  logic                     einv_q, einv_d;
  logic                     eto_q, eto_d;
  logic                     hit_q, ack_q;
  logic [31:0]              dat_q, dat_d;
  logic [USER_PROJECTS-1:0] en_q, en_d;
  logic [USER_PROJECTS-1:0] prst_q, prst_d;
  logic [USER_PROJECTS-1:0] oh_d;
  logic                     sw_q, sw_d;

  logic [CFG_BITS-1:0] pin_s;
  logic                pin_chg;
  logic                acc, wb_wr, wb_clr;
  logic [6:0]          wtgt;
  logic                req, rbad;
  logic [CFG_BITS-1:0] rtgt;
  logic                unused_ok;

  project_switch_ctrl_cfg_sync #(
    .W(CFG_BITS)
  ) u_sync (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .d_i  (pin_sel_i),
    .q_o  (pin_s),
    .chg_o(pin_chg)
  );

  assign cfg_hit_o = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i == CFG_ADDRESS);
  assign acc    = cfg_hit_o & ~hit_q;
  assign wb_wr  = acc & wbs_we_i & wbs_sel_i[0];
  assign wb_clr = acc & wbs_we_i & wbs_sel_i[1] &
                  wbs_dat_i[CLR_BIT];
  assign wtgt   = wbs_dat_i[6:0];
  assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:9]};

  // A bus write in the same cycle as a pin change takes priority.
  always_comb begin
    req  = 1'b0;
    rbad = 1'b0;
    rtgt = pin_s;
    if (wb_wr) begin
      req  = 1'b1;
      rtgt = wtgt[CFG_BITS-1:0];
      rbad = (int'(wtgt) >= USER_PROJECTS);
    end else if (pinm_q && pin_chg) begin
      req  = 1'b1;
      rbad = (int'(pin_s) >= USER_PROJECTS);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
    act_d   = act_q;
    swt_d   = swt_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    pinm_d  = pinm_q;
    einv_d  = einv_q;
    eto_d   = eto_q;
    if (wb_clr) begin
      einv_d = 1'b0;
      eto_d  = 1'b0;
    end
    unique case (state_q)
      RESET_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (pend_q) begin
          pend_d = 1'b0;
          if (ptgt_q != act_q) begin
            state_d = DRAIN;
            swt_d   = ptgt_q;
          end
        end
      end
      DRAIN: begin
        if (!wbs_cyc_i) begin
          state_d = GATE;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = GATE;
          cnt_d   = '0;
          eto_d   = 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == GATE_LAST) begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
          act_d   = swt_q;
        end
      end
      default: state_d = RESET_HOLD;
    endcase
    // Requests land after consumption so a new one is never lost.
    if (req) begin
      if (rbad) begin
        einv_d = 1'b1;
      end else begin
        if (wb_wr) pinm_d = wbs_dat_i[PIN_MODE_BIT];
        if (rtgt != act_q || pend_q) begin
          pend_d = 1'b1;
          ptgt_d = rtgt;
        end
      end
    end
  end

  always_comb begin
    oh_d   = USER_PROJECTS'(onehot(int'(act_d)));
    en_d   = oh_d;
    prst_d = ~oh_d;
    sw_d   = 1'b1;
    unique case (state_d)
      RESET_HOLD: prst_d = '1;
      RUN:        sw_d = 1'b0;
      GATE: begin
        en_d   = '0;
        prst_d = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dat_d = dat_q;
    if (acc) begin
      dat_d                 = '0;
      dat_d[CFG_BITS-1:0]   = act_q;
      dat_d[PIN_MODE_BIT]   = pinm_q;
      dat_d[15:8]           = 8'(ptgt_q);
      dat_d[PEND_BIT]       = pend_q;
      dat_d[SW_BIT]         = sw_q;
      dat_d[ERR_INV_BIT]    = einv_q;
      dat_d[ERR_TO_BIT]     = eto_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= RESET_HOLD;
      cnt_q   <= '0;
      act_q   <= DEF;
      swt_q   <= DEF;
      ptgt_q  <= '0;
      pend_q  <= 1'b0;
      pinm_q  <= 1'b0;
      einv_q  <= 1'b0;
      eto_q   <= 1'b0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= USER_PROJECTS'(onehot(DEFAULT_SEL));
      prst_q  <= '1;
      sw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      swt_q   <= swt_d;
      ptgt_q  <= ptgt_d;
      pend_q  <= pend_d;
      pinm_q  <= pinm_d;
      einv_q  <= einv_d;
      eto_q   <= eto_d;
      hit_q   <= cfg_hit_o;
      ack_q   <= acc;
      dat_q   <= dat_d;
      en_q    <= en_d;
      prst_q  <= prst_d;
      sw_q    <= sw_d;
    end
  end

  assign cfg_ack_o     = ack_q;
  assign cfg_dat_o     = dat_q;
  assign active_sel_o  = act_q;
  assign proj_clk_en_o = en_q;
  assign proj_rst_o    = prst_q;
  assign switching_o   = sw_q;

endmodule

// File: tb/tb_project_switch_ctrl.sv
// Bench for project_switch_ctrl: schedule-queue model checked every
// cycle, plus directed literal checks on the key scenarios.
module tb_project_switch_ctrl;

  localparam int UP = 4;
  localparam int GC = 2;
  localparam int RC = 4;
  localparam int DT = 255;
  localparam logic [31:0] CA = 32'h300FFFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = 32'h0;
  logic [31:0] adr = 32'h0;
  logic [1:0]  pin = 2'd0;

  logic        cfg_hit_o;
  logic        cfg_ack_o;
  logic [31:0] cfg_dat_o;
  logic [1:0]  active_sel_o;
  logic [3:0]  proj_clk_en_o;
  logic [3:0]  proj_rst_o;
  logic        switching_o;

  always #5 clk = ~clk;

  project_switch_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (dat),
    .wbs_adr_i    (adr),
    .cfg_hit_o    (cfg_hit_o),
    .cfg_ack_o    (cfg_ack_o),
    .cfg_dat_o    (cfg_dat_o),
    .pin_sel_i    (pin),
    .active_sel_o (active_sel_o),
    .proj_clk_en_o(proj_clk_en_o),
    .proj_rst_o   (proj_rst_o),
    .switching_o  (switching_o)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, got, exp, $time);
  endtask

  function automatic logic [3:0] oh(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

  // Model: each pending ownership change becomes a drain phase and
  // then a queue of per-cycle (clk_en, rst, owner) expectations.
  typedef struct packed {
    logic [3:0] en;
    logic [3:0] rs;
    logic [1:0] act;
  } ent_t;

  ent_t        sched[$];
  logic        m_valid = 1'b0;
  logic [1:0]  e_act, m_ptgt, m_swt;
  logic [3:0]  e_en, e_rst;
  logic        e_sw, e_ack;
  logic [31:0] e_dat;
  logic        m_pend, m_pinm, m_einv, m_eto, m_hitp, m_drain;
  int          m_dn;
  logic [1:0]  ph [3];

  always @(posedge clk) begin : model
    logic hit, acc, wr, opend, opinm;
    logic [1:0] oact;
    logic [31:0] st;
    int t;
    ent_t s;
    if (rst) begin
      m_valid = 1'b1;
      m_pend = 0; m_ptgt = 0; m_pinm = 0; m_swt = 0;
      m_einv = 0; m_eto = 0; m_hitp = 0;
      m_drain = 0; m_dn = 0;
      ph[0] = 0; ph[1] = 0; ph[2] = 0;
      e_act = 2'd0; e_en = oh(2'd0); e_rst = 4'hF; e_sw = 1;
      e_ack = 0; e_dat = 0;
      sched.delete();
      for (int i = 0; i < RC - 1; i++) begin
        s.en = oh(2'd0); s.rs = 4'hF; s.act = 2'd0;
        sched.push_back(s);
      end
    end else begin
      hit = cyc && stb && (adr == CA);
      acc = hit && !m_hitp;
      m_hitp = hit;
      st = {12'd0, m_eto, m_einv, e_sw, m_pend, 6'd0, m_ptgt,
            m_pinm, 5'd0, e_act};
      wr = acc && we && sel[0];
      opend = m_pend; opinm = m_pinm; oact = e_act;
      if (acc && we && sel[1] && dat[8]) begin
        m_einv = 0; m_eto = 0;
      end
      if (m_drain) begin
        m_dn++;
        if (!cyc || m_dn == DT) begin
          if (cyc) m_eto = 1;
          m_drain = 0;
          for (int i = 0; i < GC; i++) begin
            s.en = 4'd0; s.rs = 4'hF; s.act = oact;
            sched.push_back(s);
          end
          for (int i = 0; i < RC; i++) begin
            s.en = oh(m_swt); s.rs = 4'hF; s.act = m_swt;
            sched.push_back(s);
          end
        end
      end else if (!e_sw && m_pend) begin
        m_pend = 0;
        if (m_ptgt != oact) begin
          m_drain = 1; m_dn = 0; m_swt = m_ptgt;
        end
      end
      if (wr) begin
        t = int'(dat[6:0]);
        if (t >= UP) m_einv = 1;
        else begin
          m_pinm = dat[7];
          if (t != int'(oact) || opend) begin
            m_pend = 1; m_ptgt = 2'(t);
          end
        end
      end else if (opinm && ph[1] != ph[2]) begin
        if (ph[1] != oact || opend) begin
          m_pend = 1; m_ptgt = ph[1];
        end
      end
      ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = pin;
      if (sched.size() > 0) begin
        s = sched.pop_front();
        e_en = s.en; e_rst = s.rs; e_act = s.act; e_sw = 1;
      end else begin
        e_en = oh(e_act); e_rst = ~oh(e_act); e_sw = m_drain;
      end
      e_ack = acc;
      if (acc) e_dat = st;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("hit", 32'(cfg_hit_o), 32'(cyc && stb && adr == CA));
      chk("active", 32'(active_sel_o), 32'(e_act));
      chk("clk_en", 32'(proj_clk_en_o), 32'(e_en));
      chk("proj_rst", 32'(proj_rst_o), 32'(e_rst));
      chk("switching", 32'(switching_o), 32'(e_sw));
      chk("ack", 32'(cfg_ack_o), 32'(e_ack));
      chk("rdata", cfg_dat_o, e_dat);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic w, input logic [3:0] s,
                    input logic [31:0] d, input logic keep,
                    output logic [31:0] rd);
    cyc = 1; stb = 1; we = w; sel = s; dat = d; adr = CA;
    tick(1);
    chk("ack_pulse", 32'(cfg_ack_o), 32'd1);
    rd = cfg_dat_o;
    stb = 0; we = 0; cyc = keep;
    tick(1);
  endtask

  initial begin
    logic [31:0] rd;
    tick(3);
    chk("rst_prst", 32'(proj_rst_o), 32'hF);
    chk("rst_en", 32'(proj_clk_en_o), 32'h1);
    chk("rst_sw", 32'(switching_o), 32'd1);
    chk("rst_dat", cfg_dat_o, 32'h0);
    rst = 0;
    tick(3);
    chk("hold4_prst", 32'(proj_rst_o), 32'hF);
    chk("hold4_en", 32'(proj_clk_en_o), 32'h1);
    tick(1);
    chk("run0_prst", 32'(proj_rst_o), 32'hE);
    chk("run0_sw", 32'(switching_o), 32'd0);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = CA;
    tick(1);
    chk("rd0_ack", 32'(cfg_ack_o), 32'd1);
    chk("rd0_dat", cfg_dat_o, 32'h0);
    tick(1);
    chk("ack_held_stb", 32'(cfg_ack_o), 32'd0);
    cyc = 0; stb = 0;
    tick(1);

    wb(1, 4'h1, 32'h2, 0, rd);
    chk("drain_sw", 32'(switching_o), 32'd1);
    chk("drain_en", 32'(proj_clk_en_o), 32'h1);
    tick(1);
    chk("gate_en", 32'(proj_clk_en_o), 32'h0);
    tick(2);
    chk("hold2_en", 32'(proj_clk_en_o), 32'h4);
    chk("hold2_act", 32'(active_sel_o), 32'd2);
    tick(4);
    chk("run2_prst", 32'(proj_rst_o), 32'hB);
    chk("run2_sw", 32'(switching_o), 32'd0);

    wb(1, 4'h1, 32'h1, 0, rd);
    wb(1, 4'h1, 32'h3, 0, rd);
    wb(0, 4'h0, 32'h0, 0, rd);
    chk("pend_sw_bits", 32'(rd[17:16]), 32'd3);
    chk("pend_tgt", 32'(rd[15:8]), 32'd3);
    tick(20);
    chk("land3_act", 32'(active_sel_o), 32'd3);
    chk("land3_sw", 32'(switching_o), 32'd0);

    wb(1, 4'h1, 32'h5, 0, rd);
    wb(0, 4'h0, 32'h0, 0, rd);
    chk("inv_flag", 32'(rd[18]), 32'd1);
    chk("inv_pend", 32'(rd[16]), 32'd0);
    tick(5);
    chk("inv_act", 32'(active_sel_o), 32'd3);

    wb(1, 4'h1, 32'h0, 1, rd);
    tick(254);
    chk("to_drain_sw", 32'(switching_o), 32'd1);
    chk("to_drain_en", 32'(proj_clk_en_o), 32'h8);
    tick(1);
    chk("to_gate_en", 32'(proj_clk_en_o), 32'h0);
    cyc = 0;
    tick(10);
    wb(0, 4'h0, 32'h0, 0, rd);
    chk("to_flags", 32'(rd[19:18]), 32'd3);
    wb(1, 4'h2, 32'h100, 0, rd);
    wb(0, 4'h0, 32'h0, 0, rd);
    chk("clr_flags", 32'(rd[19:18]), 32'd0);
    chk("to_act", 32'(rd[1:0]), 32'd0);

    wb(1, 4'h1, 32'h80, 0, rd);
    pin = 2'd1;
    tick(2);
    wb(1, 4'h1, 32'h82, 0, rd);
    tick(14);
    chk("wb_wins", 32'(active_sel_o), 32'd2);
    pin = 2'd3;
    tick(16);
    chk("pin_to3", 32'(active_sel_o), 32'd3);

    wb(1, 4'h1, 32'h1, 0, rd);
    tick(1);
    rst = 1;
    tick(2);
    chk("abort_act", 32'(active_sel_o), 32'd0);
    chk("abort_en", 32'(proj_clk_en_o), 32'h1);
    chk("abort_prst", 32'(proj_rst_o), 32'hF);
    rst = 0;
    tick(10);
    chk("abort_keep", 32'(active_sel_o), 32'd0);
    chk("abort_sw", 32'(switching_o), 32'd0);
    wb(0, 4'h0, 32'h0, 0, rd);
    chk("abort_rd", rd, 32'h0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
